// File: rtl/rs_alu_pkg.sv
// Shared types for the ALU reservation station: word/tag/opcode widths,
// CDB and entry records, and the operand snoop helper.
package rs_alu_pkg;
  localparam int WORD_W    = 32;
  localparam int ROB_IDX_W = 4;
  localparam int OPT_W     = 6;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [OPT_W-1:0]     inst_opt_t;

  localparam inst_opt_t OPT_ADD  = 6'd1;
  localparam inst_opt_t OPT_ADDI = 6'd2;
  localparam inst_opt_t OPT_BEQ  = 6'd3;

  typedef struct packed {
    logic     valid;
    rob_idx_t src;
    word_t    val;
  } cdb_t;

  typedef struct packed {
    logic     r;
    word_t    v;
    rob_idx_t q;
  } opnd_t;

  typedef struct packed {
    inst_opt_t opt;
    opnd_t     op1;
    opnd_t     op2;
    word_t     imm;
    rob_idx_t  rob_idx;
  } rs_entry_t;

  // Capture a broadcast into a waiting operand; ALU bus wins on a tag tie.
  function automatic opnd_t snoop(opnd_t o, cdb_t alu, cdb_t lsb);
    opnd_t n = o;
    if (!o.r) begin
      if (alu.valid && alu.src == o.q) begin
        n.r = 1'b1;
        n.v = alu.val;
      end else if (lsb.valid && lsb.src == o.q) begin
        n.r = 1'b1;
        n.v = lsb.val;
      end
    end
    return n;
  endfunction
endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder over a request vector.
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: buffers dispatched ops, wakes operands from the
// ALU/LSB CDB and issues the lowest-index fully-ready entry each cycle.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      clear,
  input  logic      disp_valid,
  input  inst_opt_t disp_opt,
  input  logic      disp_r1,
  input  logic      disp_r2,
  input  word_t     disp_v1,
  input  word_t     disp_v2,
  input  rob_idx_t  disp_q1,
  input  rob_idx_t  disp_q2,
  input  word_t     disp_imm,
  input  rob_idx_t  disp_rob_idx,
  output logic      rs_full,
  input  logic      cdb_alu_valid,
  input  logic      cdb_lsb_valid,
  input  rob_idx_t  cdb_alu_src,
  input  rob_idx_t  cdb_lsb_src,
  input  word_t     cdb_alu_val,
  input  word_t     cdb_lsb_val,
  output logic      alu_en,
  output inst_opt_t rs_opt,
  output word_t     rs_val1,
  output word_t     rs_val2,
  output word_t     rs_imm,
  output rob_idx_t  rs_rob_idx
);
  rs_entry_t             ent [RS_SIZE];
  logic [RS_SIZE-1:0]    busy;
  logic [RS_SIZE-1:0]    ready_vec;
  logic                  free_found, iss_found;
  logic [RS_IDX_W-1:0]   free_idx, iss_idx;
  cdb_t                  cdb_alu, cdb_lsb;
  rs_entry_t             disp_ent;

  assign cdb_alu = '{valid: cdb_alu_valid, src: cdb_alu_src, val: cdb_alu_val};
  assign cdb_lsb = '{valid: cdb_lsb_valid, src: cdb_lsb_src, val: cdb_lsb_val};

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++)
      ready_vec[i] = busy[i] & ent[i].op1.r & ent[i].op2.r;
  end

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
    .req(~busy), .found(free_found), .idx(free_idx)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_iss_sel (
    .req(ready_vec), .found(iss_found), .idx(iss_idx)
  );

  // Fullness is judged before this cycle's issue; a freed slot reopens next cycle.
  assign rs_full = ~free_found;

  always_comb begin
    disp_ent         = '0;
    disp_ent.opt     = disp_opt;
    disp_ent.imm     = disp_imm;
    disp_ent.rob_idx = disp_rob_idx;
    disp_ent.op1     = snoop('{r: disp_r1, v: disp_v1, q: disp_q1}, cdb_alu, cdb_lsb);
    disp_ent.op2     = snoop('{r: disp_r2, v: disp_v2, q: disp_q2}, cdb_alu, cdb_lsb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      alu_en     <= 1'b0;
      rs_opt     <= '0;
      rs_val1    <= '0;
      rs_val2    <= '0;
      rs_imm     <= '0;
      rs_rob_idx <= '0;
    end else if (clear) begin
      busy   <= '0;
      alu_en <= 1'b0;
    end else if (!rdy) begin
      alu_en <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          ent[i].op1 <= snoop(ent[i].op1, cdb_alu, cdb_lsb);
          ent[i].op2 <= snoop(ent[i].op2, cdb_alu, cdb_lsb);
        end
      end
      alu_en <= iss_found;
      if (iss_found) begin
        rs_opt        <= ent[iss_idx].opt;
        rs_val1       <= ent[iss_idx].op1.v;
        rs_val2       <= ent[iss_idx].op2.v;
        rs_imm        <= ent[iss_idx].imm;
        rs_rob_idx    <= ent[iss_idx].rob_idx;
        busy[iss_idx] <= 1'b0;
      end
      // Free and issuing slots never coincide: one is idle, the other busy.
      if (disp_valid && free_found) begin
        ent[free_idx]  <= disp_ent;
        busy[free_idx] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: table of per-cycle vectors plus hand sequences
// for full/drop, clear and freeze behaviour.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic      clk = 1'b0;
  logic      rst, rdy, clear, disp_valid, disp_r1, disp_r2;
  inst_opt_t disp_opt;
  word_t     disp_v1, disp_v2, disp_imm;
  rob_idx_t  disp_q1, disp_q2, disp_rob_idx;
  logic      rs_full, alu_en;
  logic      cdb_alu_valid, cdb_lsb_valid;
  rob_idx_t  cdb_alu_src, cdb_lsb_src;
  word_t     cdb_alu_val, cdb_lsb_val;
  inst_opt_t rs_opt;
  word_t     rs_val1, rs_val2, rs_imm;
  rob_idx_t  rs_rob_idx;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rs_alu dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_opt(disp_opt),
    .disp_r1(disp_r1), .disp_r2(disp_r2), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_imm(disp_imm), .disp_rob_idx(disp_rob_idx),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_alu_src(cdb_alu_src), .cdb_lsb_src(cdb_lsb_src),
    .cdb_alu_val(cdb_alu_val), .cdb_lsb_val(cdb_lsb_val),
    .alu_en(alu_en), .rs_opt(rs_opt), .rs_val1(rs_val1), .rs_val2(rs_val2),
    .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx)
  );

  typedef struct {
    logic dv; inst_opt_t opt; logic r1, r2; word_t v1, v2; rob_idx_t q1, q2;
    word_t imm; rob_idx_t rob;
    logic av; rob_idx_t as; word_t aval;
    logic lv; rob_idx_t ls; word_t lval;
    logic e_en, e_full; inst_opt_t e_opt; word_t e_v1, e_v2, e_imm; rob_idx_t e_rob;
  } vec_t;

  function automatic vec_t V();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t D(inst_opt_t opt, logic r1, word_t v1, rob_idx_t q1,
                             logic r2, word_t v2, rob_idx_t q2, word_t imm, rob_idx_t rob);
    vec_t v = V();
    v.dv = 1'b1; v.opt = opt; v.r1 = r1; v.v1 = v1; v.q1 = q1;
    v.r2 = r2; v.v2 = v2; v.q2 = q2; v.imm = imm; v.rob = rob;
    return v;
  endfunction

  function automatic vec_t A(vec_t v, rob_idx_t s, word_t x);
    vec_t n = v;
    n.av = 1'b1; n.as = s; n.aval = x;
    return n;
  endfunction

  function automatic vec_t L(vec_t v, rob_idx_t s, word_t x);
    vec_t n = v;
    n.lv = 1'b1; n.ls = s; n.lval = x;
    return n;
  endfunction

  function automatic vec_t I(vec_t v, inst_opt_t opt, word_t v1, word_t v2, word_t imm, rob_idx_t rob);
    vec_t n = v;
    n.e_en = 1'b1; n.e_opt = opt; n.e_v1 = v1; n.e_v2 = v2; n.e_imm = imm; n.e_rob = rob;
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    disp_valid = 1'b0; disp_opt = '0; disp_r1 = 1'b0; disp_r2 = 1'b0;
    disp_v1 = '0; disp_v2 = '0; disp_q1 = '0; disp_q2 = '0; disp_imm = '0; disp_rob_idx = '0;
    cdb_alu_valid = 1'b0; cdb_alu_src = '0; cdb_alu_val = '0;
    cdb_lsb_valid = 1'b0; cdb_lsb_src = '0; cdb_lsb_val = '0;
    clear = 1'b0; rdy = 1'b1; rst = 1'b0;
  endtask

  task automatic disp(inst_opt_t opt, logic r1, word_t v1, rob_idx_t q1,
                      logic r2, word_t v2, rob_idx_t q2, word_t imm, rob_idx_t rob);
    disp_valid = 1'b1; disp_opt = opt; disp_r1 = r1; disp_v1 = v1; disp_q1 = q1;
    disp_r2 = r2; disp_v2 = v2; disp_q2 = q2; disp_imm = imm; disp_rob_idx = rob;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_iss(string tag, logic [31:0] v1, logic [31:0] v2, rob_idx_t rob);
    chk({tag, " alu_en"}, 32'(alu_en), 32'd1);
    chk({tag, " rs_val1"}, rs_val1, v1);
    chk({tag, " rs_val2"}, rs_val2, v2);
    chk({tag, " rs_rob_idx"}, 32'(rs_rob_idx), 32'(rob));
  endtask

  vec_t tv[$];

  initial begin
    idle();
    rst = 1'b1;
    disp(OPT_ADD, 1'b1, 32'h1, '0, 1'b1, 32'h2, '0, 32'h3, 4'd1);
    step(); step();
    chk("reset alu_en", 32'(alu_en), 32'd0);
    chk("reset rs_full", 32'(rs_full), 32'd0);
    chk("reset rs_opt", 32'(rs_opt), 32'd0);
    chk("reset rs_val1", rs_val1, 32'd0);
    chk("reset rs_val2", rs_val2, 32'd0);
    chk("reset rs_imm", rs_imm, 32'd0);
    chk("reset rs_rob_idx", 32'(rs_rob_idx), 32'd0);
    idle();

    tv.push_back(D(OPT_ADD, 1, 32'd5, 0, 1, 32'd7, 0, 32'd0, 4'd3));
    tv.push_back(I(V(), OPT_ADD, 32'd5, 32'd7, 32'd0, 4'd3));
    tv.push_back(V());
    tv.push_back(D(OPT_ADDI, 0, 32'd0, 4'd2, 1, 32'd0, 0, 32'd4, 4'd5));
    tv.push_back(V());
    tv.push_back(L(V(), 4'd2, 32'd10));
    tv.push_back(I(V(), OPT_ADDI, 32'd10, 32'd0, 32'd4, 4'd5));
    tv.push_back(A(D(OPT_ADD, 0, 32'd0, 4'd6, 1, 32'd1, 0, 32'd0, 4'd7), 4'd6, 32'hFFFF_FFFF));
    tv.push_back(I(V(), OPT_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd7));
    tv.push_back(D(OPT_ADD, 0, 32'd0, 4'd8, 0, 32'd0, 4'd9, 32'd0, 4'd10));
    tv.push_back(L(A(V(), 4'd8, 32'h11), 4'd9, 32'h22));
    tv.push_back(I(V(), OPT_ADD, 32'h11, 32'h22, 32'd0, 4'd10));
    tv.push_back(D(OPT_BEQ, 0, 32'd0, 4'd3, 1, 32'h4, 0, 32'h40, 4'd11));
    tv.push_back(L(A(V(), 4'd3, 32'hA), 4'd3, 32'hB));
    tv.push_back(I(V(), OPT_BEQ, 32'hA, 32'h4, 32'h40, 4'd11));
    tv.push_back(V());

    foreach (tv[k]) begin
      idle();
      if (tv[k].dv)
        disp(tv[k].opt, tv[k].r1, tv[k].v1, tv[k].q1, tv[k].r2, tv[k].v2, tv[k].q2, tv[k].imm, tv[k].rob);
      cdb_alu_valid = tv[k].av; cdb_alu_src = tv[k].as; cdb_alu_val = tv[k].aval;
      cdb_lsb_valid = tv[k].lv; cdb_lsb_src = tv[k].ls; cdb_lsb_val = tv[k].lval;
      step();
      chk($sformatf("vec%0d alu_en", k), 32'(alu_en), 32'(tv[k].e_en));
      chk($sformatf("vec%0d rs_full", k), 32'(rs_full), 32'(tv[k].e_full));
      if (tv[k].e_en) begin
        chk($sformatf("vec%0d rs_opt", k), 32'(rs_opt), 32'(tv[k].e_opt));
        chk($sformatf("vec%0d rs_val1", k), rs_val1, tv[k].e_v1);
        chk($sformatf("vec%0d rs_val2", k), rs_val2, tv[k].e_v2);
        chk($sformatf("vec%0d rs_imm", k), rs_imm, tv[k].e_imm);
        chk($sformatf("vec%0d rs_rob_idx", k), 32'(rs_rob_idx), 32'(tv[k].e_rob));
      end
    end

    // Fill all entries with ops waiting on tags 0..15; entry i holds tag i.
    for (int i = 0; i < 16; i++) begin
      idle();
      chk($sformatf("fill%0d rs_full", i), 32'(rs_full), 32'd0);
      disp(OPT_ADD, 1'b0, 32'd0, 4'(i), 1'b1, 32'(i), 4'd0, 32'd0, 4'(i));
      step();
    end
    idle();
    chk("full rs_full", 32'(rs_full), 32'd1);
    chk("full alu_en", 32'(alu_en), 32'd0);
    disp(OPT_ADD, 1'b1, 32'h77, 4'd0, 1'b1, 32'h77, 4'd0, 32'd0, 4'd15);
    step(); idle();
    chk("drop alu_en0", 32'(alu_en), 32'd0);
    chk("drop rs_full0", 32'(rs_full), 32'd1);
    step();
    chk("drop alu_en1", 32'(alu_en), 32'd0);
    chk("drop rs_full1", 32'(rs_full), 32'd1);
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd9; cdb_alu_val = 32'h900;
    cdb_lsb_valid = 1'b1; cdb_lsb_src = 4'd2; cdb_lsb_val = 32'h200;
    step(); idle();
    chk("wake alu_en", 32'(alu_en), 32'd0);
    chk("wake rs_full", 32'(rs_full), 32'd1);
    step();
    chk_iss("iss2", 32'h200, 32'd2, 4'd2);
    chk("iss2 rs_full", 32'(rs_full), 32'd0);
    step();
    chk_iss("iss9", 32'h900, 32'd9, 4'd9);
    step();
    chk("after iss9 alu_en", 32'(alu_en), 32'd0);

    // Clear with one entry ready to issue, plus same-cycle dispatch and CDB.
    clear = 1'b1;
    step(); idle();
    chk("clr0 rs_full", 32'(rs_full), 32'd0);
    for (int i = 0; i < 4; i++) begin
      disp(OPT_ADD, 1'b0, 32'd0, 4'(i + 1), 1'b1, 32'd0, 4'd0, 32'd0, 4'(i));
      step();
    end
    disp(OPT_ADD, 1'b1, 32'h5, 4'd0, 1'b1, 32'h6, 4'd0, 32'd0, 4'd8);
    step(); idle();
    clear = 1'b1;
    disp(OPT_ADD, 1'b1, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0, 32'd0, 4'd9);
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd1; cdb_alu_val = 32'h5;
    step(); idle();
    chk("clr alu_en", 32'(alu_en), 32'd0);
    chk("clr rs_full", 32'(rs_full), 32'd0);
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd2; cdb_alu_val = 32'h9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post clr%0d alu_en", i), 32'(alu_en), 32'd0);
    end
    idle();

    // Freeze: a ready entry and a broadcast must both be held off.
    disp(OPT_ADD, 1'b0, 32'd0, 4'd13, 1'b1, 32'h1, 4'd0, 32'd0, 4'd13);
    step();
    disp(OPT_ADD, 1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0, 32'd0, 4'd12);
    step(); idle();
    rdy = 1'b0;
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd13; cdb_alu_val = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("frz%0d alu_en", i), 32'(alu_en), 32'd0);
    end
    idle();
    step();
    chk_iss("thaw", 32'h33, 32'h44, 4'd12);
    step();
    chk("thaw next alu_en", 32'(alu_en), 32'd0);
    step();
    chk("thaw later alu_en", 32'(alu_en), 32'd0);
    chk("thaw rs_full", 32'(rs_full), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
